// File: rtl/data_inf_arb_pkg.sv
// Shared types and helpers for the data_inf round-robin arbiter family.
package data_inf_arb_pkg;

  typedef enum logic {IDLE, GRANT} arb_state_t;

  localparam int BEAT_CNT_W = 8;

  // Index width that never collapses to zero, so single-entry vectors stay legal.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/data_inf_c_rr_arb_rr_pick.sv
// Rotating priority picker: first asserted request at or after base, searching upward modulo NUM.
module rr_pick
  import data_inf_arb_pkg::*;
#(
  parameter int NUM = 4,
  localparam int IW = clog2_min1(NUM)
) (
  input  logic [NUM-1:0] req,
  input  logic [IW-1:0]  base,
  output logic           found,
  output logic [IW-1:0]  idx
);

  localparam logic [IW:0] LP_NUM = (IW+1)'(NUM);

  logic [2*NUM-1:0] w_dbl;
  logic [NUM-1:0]   w_rot;
  logic [IW-1:0]    w_pos;
  logic [IW:0]      w_sum;

  // Rotate so base lands at bit 0, take the lowest set bit, then rotate the index back.
  always_comb begin
    w_dbl = {req, req} >> base;
    w_rot = w_dbl[NUM-1:0];
    w_pos = '0;
    for (int i = NUM - 1; i >= 0; i--) begin
      if (w_rot[i]) w_pos = IW'(i);
    end
    w_sum = {1'b0, w_pos} + {1'b0, base};
    if (w_sum >= LP_NUM) w_sum = w_sum - LP_NUM;
    idx   = w_sum[IW-1:0];
    found = |req;
  end

endmodule

// File: rtl/data_inf_c_rr_arb.sv
// Round-robin arbiter muxing NUM valid/ready requesters onto one master port with bounded bursts.
module data_inf_c_rr_arb
  import data_inf_arb_pkg::*;
#(
  parameter int NUM       = 4,
  parameter int DSIZE     = 8,
  parameter int MAX_BURST = 4,
  localparam int IW = clog2_min1(NUM)
) (
  input  logic                   clock,
  input  logic                   rst,
  input  logic [NUM-1:0]         s_valid,
  input  logic [NUM*DSIZE-1:0]   s_data,
  output logic [NUM-1:0]         s_ready,
  output logic                   m_valid,
  output logic [DSIZE-1:0]       m_data,
  input  logic                   m_ready,
  output logic                   grant_vld,
  output logic [IW-1:0]          grant_id
);

  localparam logic [BEAT_CNT_W-1:0] LP_LAST_BEAT = BEAT_CNT_W'(MAX_BURST - 1);
  localparam logic [IW-1:0]         LP_TOP_ID    = IW'(NUM - 1);

  arb_state_t             r_state;
  arb_state_t             w_state_nxt;
  logic [IW-1:0]          r_grant_id;
  logic [IW-1:0]          r_rr_ptr;
  logic [BEAT_CNT_W-1:0]  r_beat_cnt;

  logic                   w_pick_found;
  logic [IW-1:0]          w_pick_idx;
  logic                   w_in_grant;
  logic                   w_g_valid;
  logic                   w_hs;
  logic                   w_release;

  rr_pick #(
    .NUM (NUM)
  ) u_pick (
    .req   (s_valid),
    .base  (r_rr_ptr),
    .found (w_pick_found),
    .idx   (w_pick_idx)
  );

  // Release either at the end of a full burst or as soon as the owner stops offering data.
  assign w_in_grant = (r_state == GRANT);
  assign w_g_valid  = s_valid[r_grant_id];
  assign w_hs       = w_in_grant && w_g_valid && m_ready;
  assign w_release  = w_in_grant && (!w_g_valid || (w_hs && (r_beat_cnt == LP_LAST_BEAT)));

  always_ff @(posedge clock) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_pick_found) w_state_nxt = GRANT;
      GRANT:   if (w_release)    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    grant_vld = 1'b0;
    m_valid   = 1'b0;
    s_ready   = '0;
    m_data    = s_data[r_grant_id*DSIZE +: DSIZE];
    if (w_in_grant) begin
      grant_vld            = 1'b1;
      m_valid              = w_g_valid;
      s_ready[r_grant_id]  = m_ready;
    end
  end

  assign grant_id = r_grant_id;

  // The pointer only moves on release, which gives the just-served requester lowest priority.
  always_ff @(posedge clock) begin
    if (rst) begin
      r_grant_id <= '0;
      r_beat_cnt <= '0;
      r_rr_ptr   <= '0;
    end else begin
      if (!w_in_grant && w_pick_found) begin
        r_grant_id <= w_pick_idx;
        r_beat_cnt <= '0;
      end else if (w_hs) begin
        r_beat_cnt <= r_beat_cnt + 1'b1;
      end
      if (w_release) begin
        r_rr_ptr <= (r_grant_id == LP_TOP_ID) ? '0 : r_grant_id + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_data_inf_c_rr_arb.sv
// Random-stimulus bench for data_inf_c_rr_arb checked against an owner/pointer reference model.
module tb_data_inf_c_rr_arb;

  localparam int NUM       = 4;
  localparam int DSIZE     = 8;
  localparam int MAX_BURST = 4;

  logic                 clock = 1'b0;
  logic                 rst;
  logic [NUM-1:0]       s_valid;
  logic [NUM*DSIZE-1:0] s_data;
  logic [NUM-1:0]       s_ready;
  logic                 m_valid;
  logic [DSIZE-1:0]     m_data;
  logic                 m_ready;
  logic                 grant_vld;
  logic [1:0]           grant_id;

  always #5 clock = ~clock;

  data_inf_c_rr_arb #(
    .NUM       (NUM),
    .DSIZE     (DSIZE),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .clock     (clock),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_ready   (s_ready),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .m_ready   (m_ready),
    .grant_vld (grant_vld),
    .grant_id  (grant_id)
  );

  int   assertCount = 0;
  int   failCount   = 0;
  int   pValid;
  int   pReady;
  logic rstReq;
  logic checkEn;
  int   hsSeen;

  logic       tbValid [NUM];
  logic [7:0] tbData  [NUM];
  logic       accepted[NUM];

  // Reference model: current owner (-1 when nobody holds the port), beats sent, rotation pointer.
  int   mOwner  = -1;
  int   mBeats  = 0;
  int   mPtr    = 0;
  int   mLastId = 0;
  logic justReset = 1'b1;

  task automatic compare(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus();
    rst     = rstReq;
    m_ready = (int'($urandom_range(99)) < pReady);
    for (int i = 0; i < NUM; i++) begin
      if (!(tbValid[i] && !accepted[i])) begin
        tbValid[i] = (int'($urandom_range(99)) < pValid);
        if (tbValid[i]) tbData[i] = 8'($urandom_range(255));
      end
      accepted[i] = 1'b0;
      s_valid[i]  = tbValid[i];
      s_data[i*DSIZE +: DSIZE] = tbData[i];
    end
  endtask

  task automatic checkOutput();
    logic [NUM-1:0] expRdy;
    logic           expMv;
    expRdy = '0;
    expMv  = 1'b0;
    if (mOwner >= 0) begin
      expMv = tbValid[mOwner];
      if (m_ready) expRdy[mOwner] = 1'b1;
    end
    compare("grant_vld", 32'(grant_vld), 32'(mOwner >= 0));
    compare("grant_id",  32'(grant_id),  32'(mLastId));
    compare("m_valid",   32'(m_valid),   32'(expMv));
    compare("s_ready",   32'(s_ready),   32'(expRdy));
    if (expMv)     compare("m_data",       32'(m_data), 32'(tbData[mOwner]));
    if (justReset) compare("m_data_reset", 32'(m_data), 32'(tbData[0]));
    if (m_valid === 1'b1 && m_ready === 1'b1) hsSeen++;
  endtask

  task automatic modelStep();
    int idx;
    int o;
    justReset = 1'b0;
    if (rst) begin
      mOwner = -1; mBeats = 0; mPtr = 0; mLastId = 0;
      justReset = 1'b1;
      return;
    end
    if (mOwner < 0) begin
      for (int k = 0; k < NUM; k++) begin
        idx = (mPtr + k) % NUM;
        if (tbValid[idx]) begin
          mOwner = idx; mLastId = idx; mBeats = 0;
          break;
        end
      end
    end else begin
      o = mOwner;
      if (!tbValid[o]) begin
        mPtr = (o + 1) % NUM; mOwner = -1;
      end else if (m_ready) begin
        accepted[o] = 1'b1;
        mBeats++;
        if (mBeats == MAX_BURST) begin
          mPtr = (o + 1) % NUM; mOwner = -1;
        end
      end
    end
  endtask

  task automatic runCycle();
    @(negedge clock);
    applyStimulus();
    #1;
    if (checkEn) checkOutput();
    modelStep();
  endtask

  initial begin
    logic found;
    rst = 1'b1; rstReq = 1'b1; m_ready = 1'b0; s_valid = '0; s_data = '0;
    checkEn = 1'b0; pValid = 0; pReady = 100; hsSeen = 0;
    for (int i = 0; i < NUM; i++) begin
      tbValid[i] = 1'b0; tbData[i] = 8'h00; accepted[i] = 1'b0;
    end

    $display("[TB] reset");
    runCycle();
    checkEn = 1'b1;
    runCycle();

    $display("[TB] all requesters continuous");
    rstReq = 1'b0; pValid = 100; pReady = 100; hsSeen = 0;
    repeat (20) runCycle();
    compare("beats_in_20_cycles", 32'(hsSeen), 32'd16);

    $display("[TB] backpressure");
    pReady = 0;
    repeat (12) runCycle();
    pReady = 100;
    repeat (10) runCycle();

    $display("[TB] random traffic with early releases");
    pValid = 50; pReady = 70;
    repeat (400) runCycle();

    $display("[TB] reset mid-burst");
    pValid = 100; pReady = 100;
    found = 1'b0;
    for (int n = 0; n < 40 && !found; n++) begin
      runCycle();
      if (mOwner == 0 && mBeats == 2) found = 1'b1;
    end
    compare("wait_grant0_beat2", 32'(found), 32'd1);
    rstReq = 1'b1;
    runCycle();
    rstReq = 1'b0;
    runCycle();
    compare("rst_grant_vld", 32'(grant_vld), 32'd0);
    compare("rst_m_valid",   32'(m_valid),   32'd0);
    compare("rst_s_ready",   32'(s_ready),   32'd0);
    runCycle();
    compare("restart_grant_vld", 32'(grant_vld), 32'd1);
    compare("restart_grant_id",  32'(grant_id),  32'd0);

    $display("[TB] random traffic, mostly ready");
    pValid = 80; pReady = 90;
    repeat (300) runCycle();

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/data_inf_c_rr_arb.md
# data_inf_c_rr_arb

Round-robin arbiter that shares one `data_inf` master port among `NUM` `data_inf_c`-style valid/ready requesters. It sits in front of any single-consumer datapath (FIFO, AXI write packer, DMA engine) fed by several producers. Grant is held for a bounded burst, then rotated, so no requester can starve the others. The selected requester's data is passed through to the master combinationally, so the granted path adds no latency.

## Interface
Parameters:
- `NUM`, default 4: number of requesters, 2..16.
- `DSIZE`, default 8: data width in bits.
- `MAX_BURST`, default 4: maximum accepted beats per grant, 1..255.

Ports:
- `clock`, input, 1: the single clock of the block.
- `rst`, input, 1: synchronous, active-high reset.
- `s_valid`, input, NUM: requester `i` valid.
- `s_data`, input, NUM*DSIZE: requester `i` data, at bits `[i*DSIZE +: DSIZE]`.
- `s_ready`, output, NUM: requester `i` ready.
- `m_valid`, output, 1: master valid.
- `m_data`, output, DSIZE: master data.
- `m_ready`, input, 1: master ready.
- `grant_vld`, output, 1: a grant is active (state GRANT).
- `grant_id`, output, $clog2(NUM): index of the granted requester.

## Operation
- Handshake: a beat transfers on a port when valid and ready are both high at a rising edge. Requesters must hold valid and data stable until the handshake completes.
- States are IDLE and GRANT.
- **IDLE**
  - `m_valid`=0 and `s_ready`=0.
  - If any `s_valid` is high, pick the first asserted index at or after `rr_ptr`, searching upward modulo NUM.
  - Register the pick into `grant_id`, clear `beat_cnt`, and enter GRANT next cycle.
- **GRANT**, with g = `grant_id`:
  - `m_valid` = `s_valid[g]`.
  - `m_data` = `s_data[g]`.
  - `s_ready[g]` = `m_ready`; all other `s_ready` are 0.
  - Each master handshake increments `beat_cnt` (8-bit).
- **Release from GRANT to IDLE** on either condition:
  - (a) a handshake occurs with `beat_cnt == MAX_BURST-1`;
  - (b) `s_valid[g]`=0 in the cycle.
  - On release, `rr_ptr` ← (g+1) mod NUM, wrapping from NUM-1 to 0.
- `rr_ptr` changes only on release.

## Timing
- Reset values:
  - state = IDLE, `rr_ptr`=0, `grant_id`=0, `beat_cnt`=0;
  - `grant_vld`=0, `m_valid`=0, `s_ready`=0;
  - `m_data` = `s_data[0]`, don't-care while `m_valid`=0.
- Latency:
  - Request to grant: `s_valid` high in IDLE at cycle t gives `grant_vld`=1 and the first possible handshake at t+1.
  - Datapath through an active grant: 0 cycles.
- Bubbles:
  - After every release there is exactly one IDLE cycle before the next grant.
  - Sustained throughput with all requesters busy is MAX_BURST/(MAX_BURST+1).
- `MAX_BURST`=1: each grant carries exactly one beat.
- Release on (b) happens in the same cycle valid is seen low, so the state is IDLE at the next edge.
- Simultaneous requests in IDLE: the rotating priority from `rr_ptr` decides; the requester just released has the lowest priority.
- `m_ready` low throughout GRANT: grant is held indefinitely and `beat_cnt` is frozen. No timeout.
- Requests on non-granted ports during GRANT are ignored and their `s_ready` stays 0.
- Reset mid-burst: the next edge gives IDLE with all outputs at reset values. Partially sent bursts are not resumed.

## Structure
- Package `data_inf_arb_pkg` holds:
  - `typedef enum logic {IDLE, GRANT} arb_state_t`;
  - function `clog2_min1` (returns at least 1, used for width).
- Sub-module `rr_pick`, combinational:
  - inputs: `req[NUM]`, `base[$clog2(NUM)]`;
  - outputs: `found`, `idx`.
  - Implemented as a rotate, priority-encode, un-rotate. Reusable by other arbiters.
- Top contains the FSM, `beat_cnt`, `rr_ptr` and the output muxes.

## Test plan
NUM=4, DSIZE=8, MAX_BURST=4.
- **Single requester:** req 2 streams 0x10..0x15 with `m_ready`=1 → grant 2, beats 0x10–0x13, 1 idle cycle, grant 2 again, 0x14–0x15, release on valid low; `rr_ptr`=3.
- **All four continuous after reset:** grant order 0,1,2,3,0; 4 beats each; exactly 1 bubble between grants; 16 beats in 20 cycles.
- **Backpressure:** grant 1, `m_ready`=0 for 10 cycles mid-burst → `m_data` stable, `beat_cnt` held; burst completes with 4 total beats, then rotates.
- **Early release:** req 0 sends 2 beats then drops valid while req 3 is waiting → release after beat 2; grant 3 on the following cycle+1; `rr_ptr`=1 afterward.
- **Fairness:** req 1 and req 2 both continuous, starting with `rr_ptr`=2 → grant 2 first, then 1, then 2; neither gets two consecutive grants.
- **Reset mid-burst:** assert `rst` during beat 3 of grant 0 → next cycle `grant_vld`=0, `m_valid`=0, `s_ready`=0, `rr_ptr`=0; after release, arbitration restarts from index 0.
